alion_fetch_align: RTL and testbench

Instruction fetch aligner for the alion core. It sits between the core's native instruction-memory port and the decode stage. It issues word-aligned 32-bit fetches, holds the returned halfwords in a 4-entry queue, and delivers one RV32IC instruction per handshake: 16-bit or 32-bit, aligned on any halfword, including 32-bit instructions that straddle two memory words. Redirects (branch/trap) flush the queue, and any fetch still in flight is discarded when it returns.

---
 rtl/alion_fetch_align.sv | 119 +++++++++++
 tb/tb_alion_fetch_align.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alion_fetch_align.sv
// Instruction fetch aligner: word-aligned fetches into a 4-halfword queue,
// one RV32IC instruction (16- or 32-bit, any halfword alignment) per handshake.
module alion_fetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins_pc,
    output logic [31:0] ins_data,
    output logic        ins_rvc
);

    logic [15:0] hq [4];
    logic [2:0]  cnt;
    logic [31:0] hpc;
    logic [31:1] fpc;
    logic        drop;

    logic        compressed;
    logic        deq;
    logic        hs;
    logic        enq;
    logic [2:0]  deq_n;
    logic [2:0]  enq_n;
    logic [2:0]  cnt_nx;
    logic [31:1] fpc_nx;
    logic [1:0]  base;
    logic [15:0] hq_sh [4];
    logic [15:0] hq_nx [4];

    assign compressed = (hq[0][1:0] != 2'b11);
    assign ins_valid  = compressed ? (cnt >= 3'd1) : (cnt >= 3'd2);
    assign ins_data   = compressed ? {16'h0000, hq[0]} : {hq[1], hq[0]};
    assign ins_pc     = hpc;
    assign ins_rvc    = compressed;
    assign mem_instr  = 1'b1;

    assign deq    = ins_valid && ins_ready;
    assign hs     = mem_valid && mem_ready;
    assign enq    = hs && !drop;
    assign deq_n  = deq ? (compressed ? 3'd1 : 3'd2) : 3'd0;
    assign enq_n  = enq ? (fpc[1] ? 3'd1 : 3'd2) : 3'd0;
    assign cnt_nx = cnt - deq_n + enq_n;
    assign fpc_nx = enq ? {fpc[31:2] + 30'd1, 1'b0} : fpc;

    // Shift out consumed halfwords first, then append behind what remains
    always_comb begin
        hq_sh = hq;
        case (deq_n)
            3'd1: begin
                hq_sh[0] = hq[1];
                hq_sh[1] = hq[2];
                hq_sh[2] = hq[3];
                hq_sh[3] = 16'h0000;
            end
            3'd2: begin
                hq_sh[0] = hq[2];
                hq_sh[1] = hq[3];
                hq_sh[2] = 16'h0000;
                hq_sh[3] = 16'h0000;
            end
            default: ;
        endcase
        hq_nx = hq_sh;
        base  = cnt[1:0] - deq_n[1:0];
        if (enq) begin
            if (fpc[1]) begin
                hq_nx[base] = mem_rdata[31:16];
            end else begin
                hq_nx[base]         = mem_rdata[15:0];
                hq_nx[base + 2'd1]  = mem_rdata[31:16];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) hq[i] <= 16'h0000;
            cnt       <= 3'd0;
            drop      <= 1'b0;
            hpc       <= RESET_PC & ~32'd1;
            fpc       <= RESET_PC[31:1];
            mem_valid <= 1'b0;
            mem_addr  <= 32'h0000_0000;
        end else if (redir_valid) begin
            cnt <= 3'd0;
            hpc <= redir_pc & ~32'd1;
            fpc <= redir_pc[31:1];
            // A stalled request cannot be withdrawn; mark it for discard instead
            if (mem_valid && !mem_ready) begin
                drop <= 1'b1;
            end else begin
                drop      <= 1'b0;
                mem_valid <= 1'b1;
                mem_addr  <= {redir_pc[31:2], 2'b00};
            end
        end else begin
            hq  <= hq_nx;
            cnt <= cnt_nx;
            fpc <= fpc_nx;
            if (deq) hpc <= hpc + (compressed ? 32'd2 : 32'd4);
            if (hs) drop <= 1'b0;
            if (!mem_valid || mem_ready) begin
                mem_valid <= (cnt_nx <= 3'd2);
                mem_addr  <= {fpc_nx[31:2], 2'b00};
            end
        end
    end

endmodule

// File: tb/tb_alion_fetch_align.sv
// Directed bench for alion_fetch_align: sequential fetch, RVC/straddle,
// redirects (odd target, stalled fetch), backpressure, reset and wrap.
module tb_alion_fetch_align;

    logic        clk = 1'b0;
    logic        resetn;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins_pc;
    logic [31:0] ins_data;
    logic        ins_rvc;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] mem [logic [31:0]];

    alion_fetch_align #(.RESET_PC(32'h0000_0100)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .redir_valid(redir_valid),
        .redir_pc   (redir_pc),
        .mem_valid  (mem_valid),
        .mem_instr  (mem_instr),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .ins_pc     (ins_pc),
        .ins_data   (ins_data),
        .ins_rvc    (ins_rvc)
    );

    always #5 clk = ~clk;

    // Unlisted addresses hold a 32-bit instruction tagged with its address
    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[23:0], 8'h13};
    endfunction

    always @(negedge clk) mem_rdata = rd(mem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ins(input string tag, input logic [31:0] pc, input logic [31:0] data,
                           input logic rvc);
        chk({tag, "_valid"}, {31'd0, ins_valid}, 32'd1);
        chk({tag, "_pc"}, ins_pc, pc);
        chk({tag, "_data"}, ins_data, data);
        chk({tag, "_rvc"}, {31'd0, ins_rvc}, {31'd0, rvc});
    endtask

    initial begin
        mem_rdata   = 32'h0;
        resetn      = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = 32'h0;
        mem_ready   = 1'b1;
        ins_ready   = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_ins_valid", {31'd0, ins_valid}, 32'd0);
        chk("rst_ins_pc", ins_pc, 32'h100);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_instr", {31'd0, mem_instr}, 32'd1);

        // Sequential 32-bit instructions
        resetn = 1'b1;
        tick();
        chk("seq_req_valid", {31'd0, mem_valid}, 32'd1);
        chk("seq_req_addr", mem_addr, 32'h100);
        tick();
        chk_ins("seq0", 32'h100, 32'h0001_0013, 1'b0);
        chk("seq0_next_addr", mem_addr, 32'h104);
        tick();
        chk_ins("seq1", 32'h104, 32'h0001_0413, 1'b0);
        tick();
        chk_ins("seq2", 32'h108, 32'h0001_0813, 1'b0);

        // Mixed RVC and straddling 32-bit instruction, restarted from reset
        mem[32'h100] = 32'h0513_4501;
        mem[32'h104] = 32'h0013_1234;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        chk("mix_req_addr", mem_addr, 32'h100);
        tick();
        chk_ins("mix_rvc", 32'h100, 32'h0000_4501, 1'b1);
        tick();
        chk_ins("mix_straddle", 32'h102, 32'h1234_0513, 1'b0);
        chk("mix_full_no_req", {31'd0, mem_valid}, 32'd0);
        tick();
        chk("mix_partial", {31'd0, ins_valid}, 32'd0);
        chk("mix_refill_valid", {31'd0, mem_valid}, 32'd1);
        chk("mix_refill_addr", mem_addr, 32'h108);
        tick();
        chk_ins("mix_straddle2", 32'h106, 32'h0813_0013, 1'b0);

        // Redirect to an odd halfword (bit 0 of the target is ignored)
        mem[32'h204] = 32'h4505_dead;
        redir_valid = 1'b1;
        redir_pc    = 32'h207;
        tick();
        redir_valid = 1'b0;
        chk("odd_req_valid", {31'd0, mem_valid}, 32'd1);
        chk("odd_req_addr", mem_addr, 32'h204);
        chk("odd_flushed", {31'd0, ins_valid}, 32'd0);
        tick();
        chk_ins("odd_first", 32'h206, 32'h0000_4505, 1'b1);
        chk("odd_next_addr", mem_addr, 32'h208);

        // Redirect while a fetch is stalled
        redir_valid = 1'b1;
        redir_pc    = 32'h300;
        tick();
        redir_valid = 1'b0;
        mem_ready   = 1'b0;
        mem[32'h300] = 32'h4501_4501;
        tick();
        chk("stall_addr", mem_addr, 32'h300);
        redir_valid = 1'b1;
        redir_pc    = 32'h400;
        tick();
        redir_valid = 1'b0;
        chk("stall_hold_valid", {31'd0, mem_valid}, 32'd1);
        chk("stall_hold_addr", mem_addr, 32'h300);
        chk("stall_flushed", {31'd0, ins_valid}, 32'd0);
        tick();
        chk("stall_hold_addr2", mem_addr, 32'h300);
        mem_ready = 1'b1;
        tick();
        chk("drop_no_ins", {31'd0, ins_valid}, 32'd0);
        chk("drop_next_valid", {31'd0, mem_valid}, 32'd1);
        chk("drop_next_addr", mem_addr, 32'h400);
        tick();
        chk_ins("drop_first", 32'h400, 32'h0004_0013, 1'b0);

        // Backpressure fills the queue and stops fetching
        ins_ready   = 1'b0;
        redir_valid = 1'b1;
        redir_pc    = 32'h500;
        tick();
        redir_valid = 1'b0;
        tick();
        chk("bp_second_req", mem_addr, 32'h504);
        tick();
        chk("bp_full_idle", {31'd0, mem_valid}, 32'd0);
        chk_ins("bp_head", 32'h500, 32'h0005_0013, 1'b0);
        tick();
        chk("bp_still_idle", {31'd0, mem_valid}, 32'd0);
        ins_ready = 1'b1;
        tick();
        chk_ins("bp_resume1", 32'h504, 32'h0005_0413, 1'b0);
        chk("bp_refetch", mem_addr, 32'h508);
        tick();
        chk_ins("bp_resume2", 32'h508, 32'h0005_0813, 1'b0);

        // Reset in the middle of a stalled request
        mem_ready   = 1'b0;
        redir_valid = 1'b1;
        redir_pc    = 32'h600;
        tick();
        redir_valid = 1'b0;
        chk("mid_req_valid", {31'd0, mem_valid}, 32'd1);
        resetn = 1'b0;
        tick();
        chk("mid_rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("mid_rst_ins_valid", {31'd0, ins_valid}, 32'd0);
        chk("mid_rst_ins_pc", ins_pc, 32'h100);
        resetn    = 1'b1;
        mem_ready = 1'b1;
        tick();

        // Address wrap at the top of memory
        redir_valid = 1'b1;
        redir_pc    = 32'hFFFF_FFFC;
        tick();
        redir_valid = 1'b0;
        chk("wrap_req_addr", mem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_next_addr", mem_addr, 32'h0);
        chk("wrap_next_valid", {31'd0, mem_valid}, 32'd1);
        chk_ins("wrap_top", 32'hFFFF_FFFC, 32'hFFFF_FC13, 1'b0);
        tick();
        chk_ins("wrap_zero", 32'h0, 32'h0000_0013, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
